// File: rtl/ebu_rr_arbiter.sv
// Round-robin AHB bus arbiter with burst tracking and lock support.
//
// Grants the bus to one requester at a time. The owner keeps the bus until the
// last beat of its burst; the burst length comes from the winner's HBURSTReq
// and is latched at grant time. A locked owner is re-granted back-to-back.
// Otherwise the next owner is picked round-robin, and the previous owner gets
// the lowest priority.
//
// Ports:
//   HCLK       - bus clock, rising-edge active
//   HRESETn    - asynchronous active-low reset
//   Req        - per-requester bus request (bit i = requester i)
//   Lock       - per-requester lock; the owner keeps the bus across bursts
//   HBURSTReq  - per-requester HBURST, requester i at bits [3i+2:3i]
//   HREADY     - beat complete / bus ready
//   Grant      - registered one-hot grant, all-zero when idle
//   HBURST     - burst type latched from the granted requester
//   BeatCount  - beats completed in the current burst
//   FinalBeat  - the current beat is the last beat of the burst
//   Busy       - a requester owns the bus
module ebu_rr_arbiter #(
    parameter int unsigned NREQ = 3
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic [NREQ-1:0]   Req,
    input  logic [NREQ-1:0]   Lock,
    input  logic [3*NREQ-1:0] HBURSTReq,
    input  logic              HREADY,
    output logic [NREQ-1:0]   Grant,
    output logic [2:0]        HBURST,
    output logic [3:0]        BeatCount,
    output logic              FinalBeat,
    output logic              Busy
);

    localparam int unsigned IdxW = $clog2(NREQ);

    typedef enum logic {StIdle, StOwn} state_e;

    state_e          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [2:0]      hburst_q, hburst_d;
    logic [3:0]      beat_q, beat_d;
    logic [3:0]      thresh_q, thresh_d;
    logic [IdxW-1:0] last_q, last_d;

    logic            win_found;
    logic [IdxW-1:0] win_idx;
    logic [NREQ-1:0] win_grant;
    logic [2:0]      win_burst;
    logic [2:0]      own_burst;
    logic            own_lock;
    logic            final_beat;

    // HBURST[2:1] selects the burst length: SINGLE/INCR, 4, 8 or 16 beats.
    function automatic logic [3:0] burst_thresh(input logic [2:0] burst);
        logic [3:0] t;
        case (burst[2:1])
            2'b00:   t = 4'd0;
            2'b01:   t = 4'd3;
            2'b10:   t = 4'd7;
            default: t = 4'd15;
        endcase
        return t;
    endfunction

    // Scan upward from last_q + 1 with wrap; last_q itself is checked last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_grant = '0;
        win_burst = '0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (!win_found && Req[i] && (i == ((32'(last_q) + off) % NREQ))) begin
                    win_found    = 1'b1;
                    win_idx      = IdxW'(i);
                    win_grant    = '0;
                    win_grant[i] = 1'b1;
                    win_burst    = HBURSTReq[3*i +: 3];
                end
            end
        end
    end

    // The current owner is always last_q: a lock re-grant leaves it unchanged.
    always_comb begin
        own_burst = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (IdxW'(i) == last_q) begin
                own_burst = HBURSTReq[3*i +: 3];
            end
        end
    end

    assign own_lock   = |(Lock & grant_q);
    assign final_beat = (state_q == StOwn) && (beat_q == thresh_q);

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        hburst_d = hburst_q;
        beat_d   = beat_q;
        thresh_d = thresh_q;
        last_d   = last_q;
        unique case (state_q)
            StIdle: begin
                grant_d = '0;
                if (win_found) begin
                    state_d  = StOwn;
                    grant_d  = win_grant;
                    hburst_d = win_burst;
                    thresh_d = burst_thresh(win_burst);
                    beat_d   = 4'd0;
                    last_d   = win_idx;
                end
            end
            StOwn: begin
                if (HREADY) begin
                    if (!final_beat) begin
                        beat_d = beat_q + 4'd1;
                    end else if (own_lock) begin
                        hburst_d = own_burst;
                        thresh_d = burst_thresh(own_burst);
                        beat_d   = 4'd0;
                    end else if (win_found) begin
                        grant_d  = win_grant;
                        hburst_d = win_burst;
                        thresh_d = burst_thresh(win_burst);
                        beat_d   = 4'd0;
                        last_d   = win_idx;
                    end else begin
                        state_d = StIdle;
                        grant_d = '0;
                        beat_d  = 4'd0;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
                beat_d  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            hburst_q <= 3'b000;
            beat_q   <= 4'd0;
            thresh_q <= 4'd0;
            last_q   <= IdxW'(NREQ - 1);
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            hburst_q <= hburst_d;
            beat_q   <= beat_d;
            thresh_q <= thresh_d;
            last_q   <= last_d;
        end
    end

    assign Grant     = grant_q;
    assign HBURST    = hburst_q;
    assign BeatCount = beat_q;
    assign FinalBeat = final_beat;
    assign Busy      = (state_q == StOwn);

endmodule

// File: tb/tb_ebu_rr_arbiter.sv
// Directed testbench for ebu_rr_arbiter (NREQ = 3). Inputs change and outputs
// are sampled on the falling clock edge; the DUT updates on the rising edge.
module tb_ebu_rr_arbiter;

    localparam int unsigned NREQ = 3;

    logic              HCLK;
    logic              HRESETn;
    logic [NREQ-1:0]   Req;
    logic [NREQ-1:0]   Lock;
    logic [3*NREQ-1:0] HBURSTReq;
    logic              HREADY;
    logic [NREQ-1:0]   Grant;
    logic [2:0]        HBURST;
    logic [3:0]        BeatCount;
    logic              FinalBeat;
    logic              Busy;

    int n_tests = 0;
    int n_fail  = 0;

    ebu_rr_arbiter #(
        .NREQ(NREQ)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .Req       (Req),
        .Lock      (Lock),
        .HBURSTReq (HBURSTReq),
        .HREADY    (HREADY),
        .Grant     (Grant),
        .HBURST    (HBURST),
        .BeatCount (BeatCount),
        .FinalBeat (FinalBeat),
        .Busy      (Busy)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // One rising edge, then back to the falling edge for sampling/driving.
    task automatic step();
        @(posedge HCLK);
        @(negedge HCLK);
    endtask

    // Holds reset for two cycles and returns at a falling edge with reset still low.
    task automatic hold_reset();
        HRESETn   = 1'b0;
        Req       = '0;
        Lock      = '0;
        HBURSTReq = '0;
        HREADY    = 1'b1;
        @(negedge HCLK);
        @(negedge HCLK);
    endtask

    initial begin
        HRESETn   = 1'b0;
        Req       = '0;
        Lock      = '0;
        HBURSTReq = '0;
        HREADY    = 1'b1;

        // Reset state
        hold_reset();
        check_eq("rst_grant", 32'(Grant), 32'h0);
        check_eq("rst_hburst", 32'(HBURST), 32'h0);
        check_eq("rst_beat", 32'(BeatCount), 32'h0);
        check_eq("rst_final", 32'(FinalBeat), 32'h0);
        check_eq("rst_busy", 32'(Busy), 32'h0);

        // Single INCR4 from requester 0, first edge after reset release
        Req       = 3'b001;
        HBURSTReq = 9'b000_000_011;
        HRESETn   = 1'b1;
        step();
        check_eq("incr4_grant", 32'(Grant), 32'h1);
        check_eq("incr4_hburst", 32'(HBURST), 32'h3);
        check_eq("incr4_busy", 32'(Busy), 32'h1);
        Req = 3'b000;
        for (int b = 0; b < 4; b++) begin
            check_eq("incr4_beat", 32'(BeatCount), 32'(b));
            check_eq("incr4_final", 32'(FinalBeat), (b == 3) ? 32'h1 : 32'h0);
            step();
        end
        check_eq("incr4_idle_grant", 32'(Grant), 32'h0);
        check_eq("incr4_idle_busy", 32'(Busy), 32'h0);
        check_eq("incr4_idle_beat", 32'(BeatCount), 32'h0);

        // Round robin over SINGLE transfers, back-to-back
        hold_reset();
        Req     = 3'b111;
        HRESETn = 1'b1;
        begin
            logic [2:0] rr_exp [4];
            rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
            for (int k = 0; k < 4; k++) begin
                step();
                check_eq("rr_grant", 32'(Grant), 32'(rr_exp[k]));
                check_eq("rr_busy", 32'(Busy), 32'h1);
                check_eq("rr_final", 32'(FinalBeat), 32'h1);
            end
        end

        // INCR8 to requester 1 with HREADY low every other cycle
        hold_reset();
        Req       = 3'b010;
        HBURSTReq = 9'b000_101_000;
        HRESETn   = 1'b1;
        step();
        Req = 3'b000;
        check_eq("incr8_hburst", 32'(HBURST), 32'h5);
        for (int k = 0; k < 16; k++) begin
            HREADY = (k % 2 == 1);
            check_eq("incr8_grant", 32'(Grant), 32'h2);
            check_eq("incr8_beat", 32'(BeatCount), 32'(k / 2));
            check_eq("incr8_final", 32'(FinalBeat), (k / 2 == 7) ? 32'h1 : 32'h0);
            step();
        end
        HREADY = 1'b1;
        check_eq("incr8_end_grant", 32'(Grant), 32'h0);
        check_eq("incr8_end_busy", 32'(Busy), 32'h0);

        // Locked requester 0 keeps the bus, then yields to requester 1
        hold_reset();
        Req       = 3'b011;
        Lock      = 3'b001;
        HBURSTReq = 9'b000_000_011;
        HRESETn   = 1'b1;
        step();
        check_eq("lock_grant0", 32'(Grant), 32'h1);
        step();
        step();
        step();
        check_eq("lock_final", 32'(FinalBeat), 32'h1);
        step();
        check_eq("lock_regrant", 32'(Grant), 32'h1);
        check_eq("lock_regrant_beat", 32'(BeatCount), 32'h0);
        Lock = 3'b000;
        step();
        step();
        step();
        check_eq("lock_final2", 32'(FinalBeat), 32'h1);
        check_eq("lock_hold", 32'(Grant), 32'h1);
        step();
        check_eq("unlock_grant", 32'(Grant), 32'h2);

        // Asynchronous reset in the middle of an INCR16
        hold_reset();
        Req       = 3'b001;
        HBURSTReq = 9'b000_000_111;
        HRESETn   = 1'b1;
        step();
        Req = 3'b000;
        for (int k = 0; k < 5; k++) step();
        check_eq("incr16_beat5", 32'(BeatCount), 32'h5);
        #2;
        HRESETn = 1'b0;
        #1;
        check_eq("async_grant", 32'(Grant), 32'h0);
        check_eq("async_beat", 32'(BeatCount), 32'h0);
        check_eq("async_busy", 32'(Busy), 32'h0);
        @(negedge HCLK);
        Req     = 3'b110;
        HRESETn = 1'b1;
        step();
        check_eq("post_rst_grant", 32'(Grant), 32'h2);

        // Requester 2 drops Req and changes HBURSTReq mid-burst
        hold_reset();
        Req       = 3'b100;
        HBURSTReq = 9'b011_000_000;
        HRESETn   = 1'b1;
        step();
        Req       = 3'b000;
        HBURSTReq = 9'b111_000_000;
        for (int b = 0; b < 4; b++) begin
            check_eq("drop_grant", 32'(Grant), 32'h4);
            check_eq("drop_hburst", 32'(HBURST), 32'h3);
            check_eq("drop_final", 32'(FinalBeat), (b == 3) ? 32'h1 : 32'h0);
            step();
        end
        check_eq("drop_end_grant", 32'(Grant), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
